// File: rtl/sprite_rom_arbiter.sv
// ----------------------------------------------------------------------------
// sprite_rom_arbiter
//
// Shares one synchronous sprite ROM (1-cycle registered read) between
// N_REQ sprite pixel fetchers. One read is granted per vga_clk cycle by
// round-robin. The winning address is registered towards the ROM, and the
// returned word is tagged with its owner two cycles after acceptance.
//
// Ports:
//   vga_clk      in   sole clock, rising edge
//   reset        in   asynchronous, active-high reset
//   en           in   grant enable (reads already accepted still complete)
//   req          in   [N_REQ]        per-requester read request (level)
//   addr         in   [N_REQ*ADDR_W] requester i at [i*ADDR_W +: ADDR_W]
//   gnt          out  [N_REQ]        combinational one-hot accept
//   rom_address  out  [ADDR_W]       registered ROM address
//   rom_q        in   [DATA_W]       ROM read data
//   rd_valid     out  [N_REQ]        one-hot owner of rd_data
//   rd_data      out  [DATA_W]       ROM data pass-through
// ----------------------------------------------------------------------------
module sprite_rom_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8
) (
    input  logic                    vga_clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    output logic [N_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]       rom_address,
    input  logic [DATA_W-1:0]       rom_q,
    output logic [N_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]       rd_data
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]  ptr_q;
    logic [PTR_W-1:0]  ptr_d;
    logic [PTR_W-1:0]  win;
    logic [PTR_W-1:0]  cand;
    logic              found;
    logic              accept;
    logic [ADDR_W-1:0] rom_address_q;
    logic [N_REQ-1:0]  s1_q;
    logic [N_REQ-1:0]  s2_q;

    // Round-robin search starting at ptr_q; first asserted request wins.
    always_comb begin
        gnt   = '0;
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = PTR_W'((32'(ptr_q) + k) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        // No accept may take effect while reset is held.
        if (found && en && !reset) begin
            gnt[win] = 1'b1;
        end
    end

    assign accept = |gnt;

    // Next pointer: one past the winner, wrapping at N_REQ.
    always_comb begin
        if (win == PTR_W'(N_REQ - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = win + PTR_W'(1);
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            ptr_q         <= '0;
            rom_address_q <= '0;
            s1_q          <= '0;
            s2_q          <= '0;
        end else begin
            // gnt is onehot(winner) on accept and zero otherwise, which is
            // exactly the stage-1 owner tag.
            s1_q <= gnt;
            s2_q <= s1_q;
            if (accept) begin
                ptr_q         <= ptr_d;
                rom_address_q <= addr[win*ADDR_W +: ADDR_W];
            end
        end
    end

    assign rom_address = rom_address_q;
    assign rd_valid    = s2_q;
    assign rd_data     = rom_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sprite_rom_arbiter
//
// Self-checking bench for sprite_rom_arbiter (N_REQ=4, ADDR_W=10, DATA_W=8).
// A 1-cycle registered ROM returning addr[7:0]^8'hA5 is attached. Expected
// grants come from a round-robin search over requester indices; expected
// read returns are kept in a cycle-indexed table filled two cycles ahead.
// ----------------------------------------------------------------------------
module tb_sprite_rom_arbiter;

    localparam int N   = 4;
    localparam int AW  = 10;
    localparam int DW  = 8;
    localparam int MAXC = 2048;

    logic          vga_clk = 1'b0;
    logic          reset   = 1'b0;
    logic          en      = 1'b1;
    logic [N-1:0]  req     = '0;
    logic [AW-1:0] a [N];
    logic [N*AW-1:0] addr_bus;
    logic [N-1:0]  gnt;
    logic [AW-1:0] rom_address;
    logic [DW-1:0] rom_q = '0;
    logic [N-1:0]  rd_valid;
    logic [DW-1:0] rd_data;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int            cyc = 0;
    int            m_ptr = 0;
    logic [AW-1:0] m_rom = '0;
    logic [N-1:0]  exp_v [MAXC];
    logic [DW-1:0] exp_d [MAXC];
    logic [N-1:0]  g_last = '0;

    always #5 vga_clk = ~vga_clk;

    assign addr_bus = {a[3], a[2], a[1], a[0]};

    always @(posedge vga_clk) rom_q <= rom_address[7:0] ^ 8'hA5;

    sprite_rom_arbiter #(
        .N_REQ  (N),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .en          (en),
        .req         (req),
        .addr        (addr_bus),
        .gnt         (gnt),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // One clock cycle: check at the falling edge, advance the model, then
    // return just after the rising edge so the caller can drive new inputs.
    // want >= 0 additionally checks gnt against a directed constant.
    task automatic tick(input int want);
        logic [N-1:0] ge;
        int w;
        @(negedge vga_clk);
        if (reset) begin
            m_ptr = 0;
            m_rom = '0;
            for (int k = 0; k < 3; k++) exp_v[cyc+k] = '0;
        end
        ge = '0;
        w  = -1;
        if (!reset && en) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (w < 0 && req[j]) w = j;
            end
        end
        if (w >= 0) ge[w] = 1'b1;
        chk("gnt", 32'(gnt), 32'(ge));
        if (want >= 0) chk("gnt_directed", 32'(gnt), want);
        chk("rd_valid", 32'(rd_valid), 32'(exp_v[cyc]));
        if (exp_v[cyc] != '0) chk("rd_data", 32'(rd_data), 32'(exp_d[cyc]));
        chk("rom_address", 32'(rom_address), 32'(m_rom));
        if (w >= 0) begin
            exp_v[cyc+2] = ge;
            exp_d[cyc+2] = a[w][7:0] ^ 8'hA5;
            m_rom        = a[w];
            m_ptr        = (w + 1) % N;
        end
        g_last = ge;
        @(posedge vga_clk);
        cyc++;
        #1;
    endtask

    initial begin
        for (int i = 0; i < MAXC; i++) begin
            exp_v[i] = '0;
            exp_d[i] = '0;
        end
        for (int i = 0; i < N; i++) a[i] = '0;

        // Reset, then idle
        #1 reset = 1'b1;
        tick(0);
        tick(0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick(0);

        // All four requesting; each advances its address after a grant
        for (int i = 0; i < N; i++) a[i] = 10'(10'h100 + i);
        req = 4'b1111;
        tick(4'b0001);
        for (int i = 0; i < N; i++) if (g_last[i]) a[i] = a[i] + 10'(N);
        tick(4'b0010);
        for (int i = 0; i < N; i++) if (g_last[i]) a[i] = a[i] + 10'(N);
        tick(4'b0100);
        for (int i = 0; i < N; i++) if (g_last[i]) a[i] = a[i] + 10'(N);
        tick(4'b1000);
        for (int i = 0; i < N; i++) if (g_last[i]) a[i] = a[i] + 10'(N);
        tick(4'b0001);
        req = '0;
        for (int i = 0; i < 3; i++) tick(0);

        // Single continuous requester at the top address
        req  = 4'b0100;
        a[2] = 10'h3FF;
        for (int i = 0; i < 3; i++) tick(4'b0100);
        req = '0;
        for (int i = 0; i < 3; i++) tick(0);

        // Two requesters with ptr=0
        reset = 1'b1;
        tick(0);
        reset = 1'b0;
        a[1] = 10'h021;
        a[3] = 10'h033;
        req  = 4'b1010;
        tick(4'b0010);
        tick(4'b1000);
        tick(4'b0010);
        tick(4'b1000);
        tick(4'b0010);
        tick(4'b1000);
        req[3] = 1'b0;
        tick(4'b0010);
        tick(4'b0010);
        req = '0;
        tick(0);
        tick(0);

        // Enable dropped right after an accept
        req  = 4'b0001;
        a[0] = 10'h055;
        tick(4'b0001);
        en   = 1'b0;
        a[0] = 10'h0AA;
        for (int i = 0; i < 3; i++) tick(0);
        req = '0;
        en  = 1'b1;
        tick(0);

        // Reset one cycle after an accept discards the in-flight read
        req  = 4'b0100;
        a[2] = 10'h012;
        tick(4'b0100);
        reset = 1'b1;
        req   = '0;
        tick(0);
        reset = 1'b0;
        req   = 4'b1111;
        tick(4'b0001);
        req = '0;
        tick(0);
        tick(0);

        // Randomized traffic honouring the hold-until-granted handshake
        for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] || g_last[i]) begin
                    req[i] = ($urandom_range(0, 2) != 0);
                    a[i]   = 10'($urandom);
                end
            end
            en    = ($urandom_range(0, 7) != 0);
            reset = ($urandom_range(0, 39) == 0);
            tick(-1);
        end
        reset = 1'b0;
        en    = 1'b1;
        req   = '0;
        for (int i = 0; i < 3; i++) tick(-1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
